// File: rtl/alu_host_seq_if.sv
// Host request/response port and ALU8 wrapper byte-serial load bus of alu_host_seq.
// slave: the sequencer side; master: the host/wrapper side (testbench).
interface alu_host_seq_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [7:0] req_a_i;
  logic [7:0] req_b_i;
  logic [7:0] req_cmd_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_lo_o;
  logic [7:0] rsp_hi_o;
  logic       rsp_err_o;
  logic [7:0] ABCmd_o;
  logic       LoadA_o;
  logic       LoadB_o;
  logic       LoadCmd_o;
  logic [7:0] ACC_i;
  logic       Done_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_cmd_i, rsp_ready_i, ACC_i, Done_i,
    output req_ready_o, rsp_valid_o, rsp_lo_o, rsp_hi_o, rsp_err_o,
    output ABCmd_o, LoadA_o, LoadB_o, LoadCmd_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_cmd_i, rsp_ready_i, ACC_i, Done_i,
    input  req_ready_o, rsp_valid_o, rsp_lo_o, rsp_hi_o, rsp_err_o,
    input  ABCmd_o, LoadA_o, LoadB_o, LoadCmd_o
  );
endinterface

// File: rtl/alu_host_seq.sv
// Host-side sequencer for the ALU8 wrapper: strobe-then-data load of A/B/Cmd, collects two result bytes.
// Optional WDONE timeout with error response when ALU_HOST_TIMEOUT_EN is defined.
module alu_host_seq #(
  parameter int unsigned TIMEOUT_CYC = 4
) (
  input logic           clk,
  input logic           reset,
  alu_host_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, SA, DA, SB, DB, SC, DC, WDONE, CHI, RSP
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, cmd_q, cmd_d;
  logic [7:0] abcmd_q, abcmd_d;
  logic       load_a_q, load_a_d, load_b_q, load_b_d, load_cmd_q, load_cmd_d;
  logic       rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d;
  logic [7:0] rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;
`ifdef ALU_HOST_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cmd_d    = cmd_q;
    abcmd_d  = abcmd_q;
    rsp_lo_d = rsp_lo_q;
    rsp_hi_d = rsp_hi_q;
`ifdef ALU_HOST_TIMEOUT_EN
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
`endif
    // The bus is updated on the edge leaving each strobe state, so the previous
    // byte is still driven while the strobe is high.
    unique case (state_q)
      IDLE: if (bus.req_valid_i && req_ready_q) begin
        a_d     = bus.req_a_i;
        b_d     = bus.req_b_i;
        cmd_d   = bus.req_cmd_i;
        state_d = SA;
      end
      SA: begin abcmd_d = a_q;   state_d = DA; end
      DA: state_d = SB;
      SB: begin abcmd_d = b_q;   state_d = DB; end
      DB: state_d = SC;
      SC: begin abcmd_d = cmd_q; state_d = DC; end
      DC: begin
`ifdef ALU_HOST_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = WDONE;
      end
      WDONE: begin
        if (bus.Done_i) begin
          rsp_lo_d = bus.ACC_i;
          state_d  = CHI;
        end
`ifdef ALU_HOST_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_lo_d  = '0;
          rsp_hi_d  = '0;
          rsp_err_d = 1'b1;
          state_d   = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      CHI: begin rsp_hi_d = bus.ACC_i; state_d = RSP; end
      RSP: if (bus.rsp_ready_i) begin
`ifdef ALU_HOST_TIMEOUT_EN
        rsp_err_d = 1'b0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered versions of the next-state decode.
    load_a_d    = (state_d == SA);
    load_b_d    = (state_d == SB);
    load_cmd_d  = (state_d == SC);
    rsp_valid_d = (state_d == RSP);
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      abcmd_q     <= '0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      load_cmd_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
`ifdef ALU_HOST_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cmd_q       <= cmd_d;
      abcmd_q     <= abcmd_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      load_cmd_q  <= load_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_hi_q    <= rsp_hi_d;
`ifdef ALU_HOST_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_lo_o    = rsp_lo_q;
  assign bus.rsp_hi_o    = rsp_hi_q;
  assign bus.ABCmd_o     = abcmd_q;
  assign bus.LoadA_o     = load_a_q;
  assign bus.LoadB_o     = load_b_q;
  assign bus.LoadCmd_o   = load_cmd_q;
`ifdef ALU_HOST_TIMEOUT_EN
  assign bus.rsp_err_o   = rsp_err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_host_seq.sv
// Self-checking bench for alu_host_seq: behavioural ALU8 wrapper model, vector table,
// corner sequences (backpressure, mid-transaction reset, WDONE timeout) and random traffic.
module tb_alu_host_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_host_seq_if bus_if ();

  alu_host_seq #(.TIMEOUT_CYC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] last_bus = 8'h00;
  bit done_kill = 1'b0;

  // Reference ALU: MUL gives the 16-bit product, otherwise {flags, result}
  // with flags = {3'b000, CO, V, Z, N, HC}.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, b, cmd);
    logic [15:0] p;
    logic [7:0]  r, nb;
    int          full, nib;
    logic        co, v, hc;
    co = 1'b0; v = 1'b0; hc = 1'b0;
    if (cmd[7]) begin
      p = 16'(a) * 16'(b);
      return p;
    end
    nb = ~b;
    case (cmd[3:0])
      4'h0: begin
        full = int'(a) + int'(b) + int'(cmd[4]);
        nib  = int'(a[3:0]) + int'(b[3:0]) + int'(cmd[4]);
        r  = full[7:0]; co = full[8]; hc = (nib > 15);
        v  = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'h1: begin
        full = int'(a) + int'(nb) + 1;
        nib  = int'(a[3:0]) + int'(nb[3:0]) + 1;
        r  = full[7:0]; co = full[8]; hc = (nib > 15);
        v  = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'h2:    r = a & b;
      4'h3:    r = a | b;
      4'h4:    r = a ^ b;
      default: r = a;
    endcase
    return {3'b000, co, v, (r == 8'h00), r[7], hc, r};
  endfunction

  // Wrapper model: captures the bus one edge after each strobe, raises Done
  // with the low byte in the first cycle after Cmd capture, then the high byte.
  logic       pend_a, pend_b, pend_c, hi_next, wr_done;
  logic [7:0] wa, wb, wr_acc, wr_hi;
  logic [15:0] wres;
  always @(posedge clk) begin
    if (reset) begin
      pend_a <= 1'b0; pend_b <= 1'b0; pend_c <= 1'b0;
      hi_next <= 1'b0; wr_done <= 1'b0; wr_acc <= 8'h00;
    end else begin
      if (pend_a) wa <= bus_if.ABCmd_o;
      if (pend_b) wb <= bus_if.ABCmd_o;
      pend_a <= bus_if.LoadA_o;
      pend_b <= bus_if.LoadB_o;
      pend_c <= bus_if.LoadCmd_o;
      if (pend_c && !done_kill) begin
        wres = alu_ref(wa, wb, bus_if.ABCmd_o);
        wr_done <= 1'b1; wr_acc <= wres[7:0]; wr_hi <= wres[15:8]; hi_next <= 1'b1;
      end else if (hi_next) begin
        wr_done <= 1'b0; wr_acc <= wr_hi; hi_next <= 1'b0;
      end else begin
        wr_done <= 1'b0; wr_acc <= $urandom;
      end
    end
  end
  assign bus_if.Done_i = wr_done;
  assign bus_if.ACC_i  = wr_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue_req(input logic [7:0] a, b, cmd);
    int j;
    j = 0;
    while (!bus_if.req_ready_o && j < 50) begin @(posedge clk); #1; j++; end
    check("req_ready_wait", 32'(bus_if.req_ready_o), 32'd1);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_a_i = a; bus_if.req_b_i = b; bus_if.req_cmd_i = cmd;
    @(posedge clk); #1;
    bus_if.req_valid_i = 1'b0;
    bus_if.req_a_i = $urandom; bus_if.req_b_i = $urandom; bus_if.req_cmd_i = $urandom;
  endtask

  task automatic do_txn(input logic [7:0] a, b, cmd, input int rdy_delay, input int exp_lat,
                        input logic [7:0] exp_lo, exp_hi, input logic exp_err);
    int j;
    bit seq_ok, stable_ok;
    logic [7:0] exp_bus, lo0, hi0;
    issue_req(a, b, cmd);
    j = 0; seq_ok = 1'b1;
    while (!bus_if.rsp_valid_o && j < 40) begin
      if (j <= 7) begin
        exp_bus = (j == 0) ? last_bus : (j <= 2) ? a : (j <= 4) ? b : cmd;
        if (bus_if.ABCmd_o !== exp_bus || bus_if.LoadA_o !== (j == 0) ||
            bus_if.LoadB_o !== (j == 2) || bus_if.LoadCmd_o !== (j == 4) ||
            bus_if.req_ready_o !== 1'b0)
          seq_ok = 1'b0;
      end
      @(posedge clk); #1; j++;
    end
    check("latency", 32'(j), 32'(exp_lat));
    check("bus_seq", 32'(seq_ok), 32'd1);
    check("rsp_lo", 32'(bus_if.rsp_lo_o), 32'(exp_lo));
    check("rsp_hi", 32'(bus_if.rsp_hi_o), 32'(exp_hi));
    check("rsp_err", 32'(bus_if.rsp_err_o), 32'(exp_err));
    lo0 = bus_if.rsp_lo_o; hi0 = bus_if.rsp_hi_o;
    stable_ok = 1'b1;
    for (int k = 0; k < rdy_delay; k++) begin
      bus_if.req_valid_i = 1'b1;
      @(posedge clk); #1;
      if (bus_if.rsp_valid_o !== 1'b1 || bus_if.rsp_lo_o !== lo0 || bus_if.rsp_hi_o !== hi0 ||
          bus_if.req_ready_o !== 1'b0 || bus_if.LoadA_o !== 1'b0)
        stable_ok = 1'b0;
    end
    bus_if.req_valid_i = 1'b0;
    if (rdy_delay > 0) check("backpressure_hold", 32'(stable_ok), 32'd1);
    bus_if.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus_if.rsp_ready_i = 1'b0;
    check("rsp_release", 32'({bus_if.rsp_valid_o, bus_if.req_ready_o, bus_if.LoadA_o, bus_if.rsp_err_o}),
          32'b0100);
    last_bus = cmd;
  endtask

  typedef struct {
    logic [7:0] a, b, cmd, lo, hi;
    int         delay;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [7:0] ra, rb, rc;
    logic [15:0] rexp;
    bit bad;
    bus_if.req_valid_i = 1'b0; bus_if.req_a_i = 8'h00; bus_if.req_b_i = 8'h00;
    bus_if.req_cmd_i = 8'h00; bus_if.rsp_ready_i = 1'b0;

    vecs[0] = '{8'h12, 8'h34, 8'h80, 8'hA8, 8'h03, 0};
    vecs[1] = '{8'hFF, 8'hFF, 8'h80, 8'h01, 8'hFE, 0};
    vecs[2] = '{8'h0F, 8'h01, 8'h00, 8'h10, 8'h01, 0};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h1C, 1};
    vecs[4] = '{8'h05, 8'h07, 8'h01, 8'hFE, 8'h02, 0};
    vecs[5] = '{8'hF0, 8'h3C, 8'h02, 8'h30, 8'h00, 0};
    vecs[6] = '{8'hAA, 8'hAA, 8'h04, 8'h00, 8'h04, 5};
    vecs[7] = '{8'h01, 8'h01, 8'h10, 8'h03, 8'h00, 2};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus_if.req_ready_o, bus_if.LoadA_o, bus_if.LoadB_o, bus_if.LoadCmd_o,
                                bus_if.rsp_valid_o, bus_if.rsp_err_o}), 32'b100000);
    check("reset_bus", 32'({bus_if.ABCmd_o, bus_if.rsp_lo_o, bus_if.rsp_hi_o}), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_txn(vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].delay, 8, vecs[i].lo, vecs[i].hi, 1'b0);

    // Reset while the sequencer is in SB abandons the transaction.
    issue_req(8'h5A, 8'hC3, 8'h80);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_ctrl", 32'({bus_if.req_ready_o, bus_if.LoadA_o, bus_if.LoadB_o, bus_if.LoadCmd_o,
                                bus_if.rsp_valid_o}), 32'b10000);
    check("midreset_bus", 32'(bus_if.ABCmd_o), 32'h0);
    bad = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus_if.rsp_valid_o || bus_if.LoadA_o || bus_if.LoadB_o || bus_if.LoadCmd_o) bad = 1'b1;
    end
    check("midreset_quiet", 32'(bad), 32'd0);
    last_bus = 8'h00;
    do_txn(8'h12, 8'h34, 8'h80, 0, 8, 8'hA8, 8'h03, 1'b0);

    // Wrapper never raises Done.
    done_kill = 1'b1;
`ifdef ALU_HOST_TIMEOUT_EN
    do_txn(8'h33, 8'h44, 8'h80, 1, 10, 8'h00, 8'h00, 1'b1);
    done_kill = 1'b0;
`else
    issue_req(8'h33, 8'h44, 8'h80);
    bad = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus_if.rsp_valid_o || bus_if.req_ready_o) bad = 1'b1;
    end
    check("wdone_wait", 32'(bad), 32'd0);
    done_kill = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_bus = 8'h00;
`endif

    for (int n = 0; n < 30; n++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      rexp = alu_ref(ra, rb, rc);
      do_txn(ra, rb, rc, int'($urandom_range(0, 3)), 8, rexp[7:0], rexp[15:8], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
